// File: rtl/beta_mem_arb.sv
// Round-robin arbiter sharing one single-ported memory between the beta core's fetch and data ports.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module beta_mem_arb #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 16,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          last_d_r;
    logic          grant_i_s;
    logic          grant_d_s;
    logic          timeout_s;
    logic          m_req_r;
    logic          m_we_r;
    logic [AW-1:0] m_addr_r;
    logic [DW-1:0] m_wdata_r;
    logic          i_rvalid_r;
    logic          d_rvalid_r;
    logic [DW-1:0] i_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic          err_r;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_r;

    // Watchdog fires on the TIMEOUT-th busy cycle without an ack; an ack in that cycle wins.
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r != ST_IDLE) && !m_ack && (cnt_r == CW'(TIMEOUT - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Busy-cycle counter, cleared at grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (grant_i_s || grant_d_s) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r != ST_IDLE) && !m_ack) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and grant logic; fetch wins a tie unless it owned the memory last.
    always_comb begin
        state_s   = state_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req && (!d_req || last_d_r)) begin
                    grant_i_s = 1'b1;
                    state_s   = ST_BUSY_I;
                end else if (d_req) begin
                    grant_d_s = 1'b1;
                    state_s   = ST_BUSY_D;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (m_ack || timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and round-robin owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            last_d_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (grant_i_s) begin
                last_d_r <= 1'b0;
            end else if (grant_d_s) begin
                last_d_r <= 1'b1;
            end else begin
                last_d_r <= last_d_r;
            end
        end
    end

    // Memory-side request: operands captured at grant, held stable until completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= {AW{1'b0}};
            m_wdata_r <= {DW{1'b0}};
        end else if (grant_i_s) begin
            m_req_r  <= 1'b1;
            m_we_r   <= 1'b0;
            m_addr_r <= i_addr;
        end else if (grant_d_s) begin
            m_req_r   <= 1'b1;
            m_we_r    <= d_we;
            m_addr_r  <= d_addr;
            m_wdata_r <= d_wdata;
        end else if ((state_r != ST_IDLE) && (m_ack || timeout_s)) begin
            m_req_r <= 1'b0;
            m_we_r  <= 1'b0;
        end else begin
            m_req_r <= m_req_r;
            m_we_r  <= m_we_r;
        end
    end

    // Response pulses and read-data capture; writes leave the rdata register untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_rdata_r  <= {DW{1'b0}};
            d_rdata_r  <= {DW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            err_r      <= 1'b0;
            if (state_r == ST_BUSY_I && m_ack) begin
                i_rvalid_r <= 1'b1;
                i_rdata_r  <= m_rdata;
            end else if (state_r == ST_BUSY_D && m_ack) begin
                d_rvalid_r <= 1'b1;
                if (!m_we_r) begin
                    d_rdata_r <= m_rdata;
                end else begin
                    d_rdata_r <= d_rdata_r;
                end
            end else if (state_r == ST_BUSY_I && timeout_s) begin
                i_rvalid_r <= 1'b1;
                i_rdata_r  <= ERR_DATA;
                err_r      <= 1'b1;
            end else if (state_r == ST_BUSY_D && timeout_s) begin
                d_rvalid_r <= 1'b1;
                d_rdata_r  <= ERR_DATA;
                err_r      <= 1'b1;
            end else begin
                i_rdata_r <= i_rdata_r;
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign i_gnt    = grant_i_s;
    assign d_gnt    = grant_d_s;
    assign i_rvalid = i_rvalid_r;
    assign d_rvalid = d_rvalid_r;
    assign i_rdata  = i_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign m_req    = m_req_r;
    assign m_we     = m_we_r;
    assign m_addr   = m_addr_r;
    assign m_wdata  = m_wdata_r;
    assign busy     = (state_r != ST_IDLE);
    assign err      = err_r;

endmodule
